// File: rtl/rs_gf_pkg.sv
// Shared GF(2^8) constants, multiplier and FSM state type for the RS(204,188) error-magnitude stage.
package rs_gf_pkg;

    localparam int unsigned GF_W    = 8;
    localparam int unsigned T       = 8;
    localparam int unsigned CNT_W   = 4;
    localparam logic [GF_W-1:0] GF_POLY = 8'h1D;
    localparam logic [GF_W-1:0] INV_EXP = 8'd254;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        INV,
        EVAL,
        PROD,
        DINV,
        OUT,
        DONE
    } em_state_t;

    // Shift-and-add multiply, reducing by x^8+x^4+x^3+x^2+1 as the multiplicand overflows.
    function automatic logic [GF_W-1:0] gf_mul(input logic [GF_W-1:0] a, input logic [GF_W-1:0] b);
        logic [GF_W-1:0] p;
        logic [GF_W-1:0] aa;
        p  = '0;
        aa = a;
        for (int i = 0; i < int'(GF_W); i++) begin
            if (b[i]) p = p ^ aa;
            aa = aa[GF_W-1] ? ({aa[GF_W-2:0], 1'b0} ^ GF_POLY) : {aa[GF_W-2:0], 1'b0};
        end
        return p;
    endfunction

endpackage

// File: rtl/gf_inv_step.sv
// One MSB-first square-and-multiply step used to build x^254 (the field inverse).
module gf_inv_step
    import rs_gf_pkg::*;
(
    input  logic [GF_W-1:0] r,
    input  logic [GF_W-1:0] x,
    input  logic            bit_sel,
    output logic [GF_W-1:0] r_next_c
);

    logic [GF_W-1:0] sq;

    // r_next = bit ? r^2 * x : r^2
    always_comb begin
        sq       = gf_mul(r, r);
        r_next_c = bit_sel ? gf_mul(sq, x) : sq;
    end

endmodule

// File: rtl/error_magnitude.sv
// Eight-lane error magnitude evaluator: e_j = Z(X_j^-1) / prod_{i!=j}(1 + X_i X_j^-1).
module error_magnitude
    import rs_gf_pkg::*;
(
    input  logic            Clk,
    input  logic            Rst,
    input  logic            start,
    input  logic [GF_W-1:0] el1, el2, el3, el4, el5, el6, el7, el8,
    input  logic [GF_W-1:0] zed1, zed2, zed3, zed4, zed5, zed6, zed7, zed8,
    output logic [GF_W-1:0] em1, em2, em3, em4, em5, em6, em7, em8
);

    em_state_t        state_q, state_d;
    logic [CNT_W-1:0] cnt_q;
    logic             last_step;
    logic             phase_act;
    logic             dinv_phase;
    logic             step_bit;
    logic [2:0]       horner_k;
    logic [2:0]       prod_i;
    logic [GF_W-1:0]  zk;
    logic [GF_W-1:0]  prod_el;

    logic [GF_W-1:0]  el_in   [T];
    logic [GF_W-1:0]  zed_in  [T];
    logic [GF_W-1:0]  el_q    [T];
    logic [GF_W-1:0]  zed_q   [T];
    logic [GF_W-1:0]  xinv_q  [T];
    logic [GF_W-1:0]  num_q   [T];
    logic [GF_W-1:0]  den_q   [T];
    logic [GF_W-1:0]  deninv_q[T];
    logic [GF_W-1:0]  em_q    [T];
    logic [GF_W-1:0]  step_r  [T];

    assign el_in  = '{el1, el2, el3, el4, el5, el6, el7, el8};
    assign zed_in = '{zed1, zed2, zed3, zed4, zed5, zed6, zed7, zed8};

    assign em1 = em_q[0];
    assign em2 = em_q[1];
    assign em3 = em_q[2];
    assign em4 = em_q[3];
    assign em5 = em_q[4];
    assign em6 = em_q[5];
    assign em7 = em_q[6];
    assign em8 = em_q[7];

    // Per-step controls shared by all lanes: exponent bit, Horner coefficient, product locator.
    always_comb begin
        last_step  = (cnt_q == CNT_W'(7));
        phase_act  = (state_q == INV) || (state_q == EVAL) || (state_q == PROD) || (state_q == DINV);
        dinv_phase = (state_q == DINV);
        step_bit   = INV_EXP[~cnt_q[2:0]];
        horner_k   = ~cnt_q[2:0];
        zk         = (horner_k == 3'd0) ? GF_W'(1) : zed_q[3'(horner_k - 3'd1)];
        prod_i     = cnt_q[2:0];
        prod_el    = el_q[prod_i];
    end

    // State register.
    always_ff @(posedge Clk) begin
        if (Rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic; each iterative phase lasts eight counter steps.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = LOAD;
            LOAD:    state_d = INV;
            INV:     if (last_step) state_d = EVAL;
            EVAL:    if (last_step) state_d = PROD;
            PROD:    if (last_step) state_d = DINV;
            DINV:    if (last_step) state_d = OUT;
            OUT:     state_d = DONE;
            DONE:    if (!start) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Step counter shared by INV, EVAL, PROD and DINV.
    always_ff @(posedge Clk) begin
        if (Rst)            cnt_q <= '0;
        else if (phase_act) cnt_q <= last_step ? '0 : CNT_W'(cnt_q + CNT_W'(1));
        else                cnt_q <= '0;
    end

    // Square-and-multiply unit per lane, fed by X_j during INV and by den_j during DINV.
    for (genvar j = 0; j < int'(T); j++) begin : g_lane
        gf_inv_step u_step (
            .r        (dinv_phase ? deninv_q[j] : xinv_q[j]),
            .x        (dinv_phase ? den_q[j]    : el_q[j]),
            .bit_sel  (step_bit),
            .r_next_c (step_r[j])
        );
    end

    // Lane datapath: latch inputs, invert locator, Horner-evaluate Z, build and invert denominator, output.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            for (int j = 0; j < int'(T); j++) begin
                el_q[j]     <= '0;
                zed_q[j]    <= '0;
                xinv_q[j]   <= '0;
                num_q[j]    <= '0;
                den_q[j]    <= '0;
                deninv_q[j] <= '0;
                em_q[j]     <= '0;
            end
        end else begin
            for (int j = 0; j < int'(T); j++) begin
                case (state_q)
                    LOAD: begin
                        el_q[j]     <= el_in[j];
                        zed_q[j]    <= zed_in[j];
                        xinv_q[j]   <= GF_W'(1);
                        num_q[j]    <= zed_in[T-1];
                        den_q[j]    <= GF_W'(1);
                        deninv_q[j] <= GF_W'(1);
                    end
                    INV:  xinv_q[j] <= step_r[j];
                    EVAL: num_q[j]  <= gf_mul(num_q[j], xinv_q[j]) ^ zk;
                    PROD: begin
                        if ((prod_i != 3'(j)) && (prod_el != '0))
                            den_q[j] <= gf_mul(den_q[j], GF_W'(1) ^ gf_mul(prod_el, xinv_q[j]));
                    end
                    DINV: deninv_q[j] <= step_r[j];
                    OUT:  em_q[j] <= (el_q[j] != '0) ? gf_mul(num_q[j], deninv_q[j]) : '0;
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_error_magnitude.sv
// Bench for error_magnitude: directed and random locator sets checked against a log/antilog GF model.
module tb_error_magnitude;

    logic       clk;
    logic       rst;
    logic       start;
    logic [7:0] el_v  [8];
    logic [7:0] zed_v [8];
    logic [7:0] em_w  [8];

    int n_checks;
    int n_fails;

    int         log_t [256];
    logic [7:0] exp_t [510];

    logic [7:0] exp_em  [8];
    logic [7:0] prev_em [8];
    logic [7:0] zero_em [8];

    error_magnitude dut (
        .Clk   (clk),
        .Rst   (rst),
        .start (start),
        .el1   (el_v[0]), .el2 (el_v[1]), .el3 (el_v[2]), .el4 (el_v[3]),
        .el5   (el_v[4]), .el6 (el_v[5]), .el7 (el_v[6]), .el8 (el_v[7]),
        .zed1  (zed_v[0]), .zed2 (zed_v[1]), .zed3 (zed_v[2]), .zed4 (zed_v[3]),
        .zed5  (zed_v[4]), .zed6 (zed_v[5]), .zed7 (zed_v[6]), .zed8 (zed_v[7]),
        .em1   (em_w[0]), .em2 (em_w[1]), .em3 (em_w[2]), .em4 (em_w[3]),
        .em5   (em_w[4]), .em6 (em_w[5]), .em7 (em_w[6]), .em8 (em_w[7])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] fmul(input logic [7:0] a, input logic [7:0] b);
        if (a == 8'h00 || b == 8'h00) return 8'h00;
        return exp_t[log_t[a] + log_t[b]];
    endfunction

    function automatic logic [7:0] finv(input logic [7:0] a);
        if (a == 8'h00) return 8'h00;
        return exp_t[255 - log_t[a]];
    endfunction

    // e_j = Z(1/X_j) / prod_{i!=j, X_i used}(1 + X_i/X_j); a zero denominator yields 0.
    task automatic model_all();
        for (int j = 0; j < 8; j++) begin
            logic [7:0] xi, p, num, den;
            if (el_v[j] == 8'h00) begin
                exp_em[j] = 8'h00;
            end else begin
                xi  = finv(el_v[j]);
                num = 8'h01;
                p   = 8'h01;
                for (int k = 1; k <= 8; k++) begin
                    p   = fmul(p, xi);
                    num = num ^ fmul(zed_v[k-1], p);
                end
                den = 8'h01;
                for (int i = 0; i < 8; i++)
                    if (i != j && el_v[i] != 8'h00)
                        den = fmul(den, 8'h01 ^ fmul(el_v[i], xi));
                exp_em[j] = (den == 8'h00) ? 8'h00 : fmul(num, finv(den));
            end
        end
    endtask

    task automatic check8(input string tag, input logic [7:0] want [8]);
        for (int j = 0; j < 8; j++) begin
            n_checks++;
            assert (em_w[j] === want[j]) else begin
                n_fails++;
                $error("FAIL %s em%0d observed=%02h expected=%02h", tag, j + 1, em_w[j], want[j]);
            end
        end
    endtask

    // One computation: start at edge 0, scramble inputs after LOAD, check hold at edge 33 and result at 34.
    task automatic do_run(input string tag, input bit hold_start);
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        if (!hold_start) start = 1'b0;
        @(posedge clk); #1;
        for (int i = 0; i < 8; i++) begin
            el_v[i]  = 8'($urandom);
            zed_v[i] = 8'($urandom);
        end
        for (int c = 2; c <= 33; c++) begin
            @(posedge clk); #1;
        end
        check8({tag, "_pre"}, prev_em);
        @(posedge clk); #1;
        check8(tag, exp_em);
        prev_em = exp_em;
        if (hold_start) begin
            for (int c = 0; c < 40; c++) begin
                @(posedge clk); #1;
            end
            check8({tag, "_hold"}, exp_em);
            start = 1'b0;
        end
        @(posedge clk); #1;
        @(posedge clk); #1;
        check8({tag, "_idle"}, exp_em);
    endtask

    task automatic clear_inputs();
        for (int i = 0; i < 8; i++) begin
            el_v[i]  = 8'h00;
            zed_v[i] = 8'h00;
        end
    endtask

    task automatic gen_random(input int nloc);
        clear_inputs();
        for (int k = 0; k < nloc; k++) begin
            int slot;
            logic [7:0] v;
            bit used;
            do begin
                slot = int'($urandom_range(0, 7));
            end while (el_v[slot] != 8'h00);
            do begin
                v = 8'($urandom_range(1, 255));
                used = 1'b0;
                for (int i = 0; i < 8; i++) if (el_v[i] == v) used = 1'b1;
            end while (used);
            el_v[slot] = v;
        end
        for (int i = 0; i < 8; i++) zed_v[i] = 8'($urandom);
    endtask

    initial begin
        logic [7:0] x;
        n_checks = 0;
        n_fails  = 0;
        x = 8'h01;
        for (int i = 0; i < 255; i++) begin
            exp_t[i]       = x;
            exp_t[i + 255] = x;
            log_t[x]       = i;
            x = x[7] ? ((x << 1) ^ 8'h1D) : (x << 1);
        end
        log_t[0] = 0;
        for (int i = 0; i < 8; i++) begin
            zero_em[i] = 8'h00;
            prev_em[i] = 8'h00;
        end

        rst   = 1'b1;
        start = 1'b0;
        clear_inputs();
        repeat (3) @(posedge clk);
        #1;
        check8("reset", zero_em);
        rst = 1'b0;

        // Single error at X = 1 with Z = 1.
        clear_inputs();
        el_v[0] = 8'h01;
        exp_em = zero_em; exp_em[0] = 8'h01;
        do_run("single_x1", 1'b0);

        // X = alpha, z1 = 3: magnitude equals 1/alpha.
        clear_inputs();
        el_v[0] = 8'h02; zed_v[0] = 8'h03;
        exp_em = zero_em; exp_em[0] = 8'h8E;
        do_run("single_x2", 1'b0);

        // Two errors, Z = 1.
        clear_inputs();
        el_v[0] = 8'h01; el_v[1] = 8'h02;
        exp_em = zero_em; exp_em[0] = 8'hF4; exp_em[1] = 8'hF5;
        do_run("double", 1'b0);

        // No locators in use, arbitrary Z.
        clear_inputs();
        for (int i = 0; i < 8; i++) zed_v[i] = 8'($urandom);
        exp_em = zero_em;
        do_run("none", 1'b0);

        // Full 8-error vector with start held high throughout.
        el_v  = '{8'd231, 8'd223, 8'd186, 8'd120, 8'd97, 8'd48, 8'd25, 8'd2};
        zed_v = '{8'd16, 8'd103, 8'd131, 8'd54, 8'd181, 8'd205, 8'd204, 8'd206};
        model_all();
        do_run("full8", 1'b1);

        // Random locator sets of varying size.
        for (int r = 0; r < 6; r++) begin
            gen_random(int'($urandom_range(1, 8)));
            model_all();
            do_run($sformatf("rand%0d", r), r[0]);
        end

        // Duplicate locators force those lanes to zero.
        gen_random(5);
        el_v[0] = 8'h05; el_v[1] = 8'h05; el_v[2] = 8'h07;
        model_all();
        do_run("dup", 1'b0);

        // Reset pulsed mid-run aborts; a fresh start then completes normally.
        gen_random(8);
        model_all();
        begin
            logic [7:0] sv_el [8];
            logic [7:0] sv_zed [8];
            sv_el  = el_v;
            sv_zed = zed_v;
            @(posedge clk); #1;
            start = 1'b1;
            @(posedge clk); #1;
            for (int c = 1; c <= 15; c++) begin
                @(posedge clk); #1;
            end
            rst = 1'b1;
            @(posedge clk); #1;
            rst   = 1'b0;
            start = 1'b0;
            check8("rst_mid", zero_em);
            for (int c = 0; c < 40; c++) begin
                @(posedge clk); #1;
            end
            check8("rst_idle", zero_em);
            prev_em = zero_em;
            el_v  = sv_el;
            zed_v = sv_zed;
            do_run("after_rst", 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
